// File: rtl/axi4_stream_pkt_rx_pkg.sv
// axi4_stream_pkt_rx_pkg: descriptor type and byte-lane popcount helper for the packet receiver
package axi4_stream_pkt_rx_pkg;
  // Descriptor fields are sized for the widest supported configuration; narrower values are zero-extended
  localparam int DESC_BYTES_W = 16;
  localparam int DESC_ID_W    = 8;
  localparam int DESC_DEST_W  = 8;
  typedef struct packed {
    logic [DESC_BYTES_W-1:0] bytes;
    logic [DESC_ID_W-1:0]    tid;
    logic [DESC_DEST_W-1:0]  tdest;
    logic                    err_ovf;
    logic                    err_hdr;
  } pkt_rx_desc_t;
  function automatic logic [7:0] popcount(input logic [63:0] v);
    popcount = '0;
    for (int i = 0; i < 64; i++) popcount = popcount + {7'd0, v[i]};
  endfunction
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle with source and destination views
interface axi4_stream_if #(
  parameter type tdata_t = logic [31:0],
  parameter type tid_t   = logic [7:0],
  parameter type tdest_t = logic [7:0],
  parameter type tuser_t = logic [31:0]
);
  localparam int NB = $bits(tdata_t) / 8;
  logic            tvalid;
  logic            tready;
  tdata_t          tdata;
  logic [NB-1:0]   tkeep;
  logic [NB-1:0]   tstrb;
  logic            tlast;
  tid_t            tid;
  tdest_t          tdest;
  tuser_t          tuser;
  modport src (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport dst (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_pkt_rx_fifo.sv
// axi4_stream_pkt_rx_fifo: registered synchronous FIFO, head visible the cycle after push
module axi4_stream_pkt_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  assign full    = count[AW];
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp];
  // Storage array carries no reset; an empty count hides its contents
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/axi4_stream_pkt_rx.sv
// axi4_stream_pkt_rx: AXI4-Stream packet receiver with beat FIFO and per-packet descriptor
module axi4_stream_pkt_rx
  import axi4_stream_pkt_rx_pkg::*;
#(
  parameter type tdata_t     = logic [31:0],
  parameter type tid_t       = logic [7:0],
  parameter type tdest_t     = logic [7:0],
  parameter type tuser_t     = logic [31:0],
  parameter int DEPTH        = 16,
  parameter int MAX_PKT_BYTES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi4_stream_if.dst                    s_axis,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output tdata_t                        rd_data,
  output logic [$bits(tdata_t)/8-1:0]   rd_keep,
  output tuser_t                        rd_user,
  output logic                          rd_last,
  output logic                          desc_valid,
  input  logic                          desc_ready,
  output pkt_rx_desc_t                  desc
);
  localparam int NB = $bits(tdata_t) / 8;
  localparam int BW = $clog2(MAX_PKT_BYTES + 1);
  localparam int FW = $bits(tdata_t) + NB + $bits(tuser_t) + 1;
  localparam logic [BW:0] MAX_B = (BW+1)'(MAX_PKT_BYTES);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;
  logic [0:0]          state;
  logic [BW-1:0]       bytes_q, bytes_n, k;
  logic [BW:0]         sum;
  tid_t                tid_q, tid_n;
  tdest_t              tdest_q, tdest_n;
  logic                ovf_q, hdr_q, ovf_n, hdr_n;
  logic                rdy_en, acc, full, empty;
  logic [FW-1:0]       rdata;
  logic [$clog2(DEPTH):0] unused_count;
  logic                unused_tstrb;
  assign unused_tstrb = ^s_axis.tstrb;
  // A pending unaccepted descriptor stalls every beat, since tready must not depend on tlast
  assign s_axis.tready = rdy_en && !full && !(desc_valid && !desc_ready);
  assign acc     = s_axis.tvalid && s_axis.tready;
  assign k       = BW'(popcount(64'(s_axis.tkeep)));
  assign sum     = {1'b0, bytes_q} + {1'b0, k};
  assign ovf_n   = state == ST_PKT && (ovf_q || sum > MAX_B);
  assign hdr_n   = state == ST_PKT && (hdr_q || s_axis.tid != tid_q || s_axis.tdest != tdest_q);
  assign bytes_n = state == ST_IDLE ? k : sum > MAX_B ? MAX_B[BW-1:0] : sum[BW-1:0];
  assign tid_n   = state == ST_IDLE ? s_axis.tid : tid_q;
  assign tdest_n = state == ST_IDLE ? s_axis.tdest : tdest_q;
  // Packet tracking: open on a non-last beat, accumulate bytes and sticky errors, close on tlast
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      bytes_q <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      ovf_q   <= 1'b0;
      hdr_q   <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (acc) begin
        state   <= s_axis.tlast ? ST_IDLE : ST_PKT;
        bytes_q <= bytes_n;
        tid_q   <= tid_n;
        tdest_q <= tdest_n;
        ovf_q   <= ovf_n;
        hdr_q   <= hdr_n;
      end
    end
  // Descriptor register: loaded on the closing beat, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      desc_valid <= 1'b0;
      desc       <= '0;
    end else if (acc && s_axis.tlast) begin
      desc_valid <= 1'b1;
      desc       <= '{bytes: DESC_BYTES_W'(bytes_n), tid: DESC_ID_W'(tid_n),
                      tdest: DESC_DEST_W'(tdest_n), err_ovf: ovf_n, err_hdr: hdr_n};
    end else if (desc_ready) begin
      desc_valid <= 1'b0;
    end
  axi4_stream_pkt_rx_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (acc),
    .pop   (rd_ready),
    .wdata ({s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (unused_count)
  );
  assign rd_valid = !empty;
  assign {rd_data, rd_keep, rd_user, rd_last} = rdata;
endmodule

// File: tb/tb_axi4_stream_pkt_rx.sv
// tb_axi4_stream_pkt_rx: directed and randomized checks of the packet receiver against a packet-level model
module tb_axi4_stream_pkt_rx;
  import axi4_stream_pkt_rx_pkg::*;
  localparam int MAXB = 4096;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [31:0] u;
    logic        l;
  } beat_t;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_valid, rd_ready, rd_last, desc_valid, desc_ready;
  logic [31:0]   rd_data, rd_user;
  logic [3:0]    rd_keep;
  pkt_rx_desc_t  desc;
  int            n_cmp = 0, n_bad = 0, n_pop = 0;
  logic          rand_rdy = 1'b0;
  beat_t         exp_q[$];
  pkt_rx_desc_t  desc_q[$];
  logic          pk_open = 1'b0, pk_hdr;
  int            pk_sum;
  logic [7:0]    pk_tid, pk_tdest;
  axi4_stream_if s_axis ();
  axi4_stream_pkt_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axis     (s_axis),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_keep    (rd_keep),
    .rd_user    (rd_user),
    .rd_last    (rd_last),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc       (desc)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Packet-level reference: collect beats, descriptor derived from whole-packet totals
  task automatic model_accept();
    beat_t b;
    pkt_rx_desc_t d;
    b = {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};
    exp_q.push_back(b);
    if (!pk_open) begin
      pk_tid = s_axis.tid;
      pk_tdest = s_axis.tdest;
      pk_sum = 0;
      pk_hdr = 1'b0;
      pk_open = 1'b1;
    end else if (s_axis.tid != pk_tid || s_axis.tdest != pk_tdest) begin
      pk_hdr = 1'b1;
    end
    pk_sum += $countones(s_axis.tkeep);
    if (s_axis.tlast) begin
      d = '0;
      d.bytes = 16'(pk_sum > MAXB ? MAXB : pk_sum);
      d.tid = pk_tid;
      d.tdest = pk_tdest;
      d.err_ovf = pk_sum > MAXB;
      d.err_hdr = pk_hdr;
      desc_q.push_back(d);
      pk_open = 1'b0;
    end
  endtask
  // One clock: evaluate handshakes just before the edge, return at the following falling edge
  task automatic step(output logic a);
    logic [127:0] e;
    if (rand_rdy) begin
      rd_ready = $urandom_range(0, 3) != 0;
      desc_ready = $urandom_range(0, 2) != 0;
    end
    #1;
    a = s_axis.tvalid && s_axis.tready;
    if (a) model_accept();
    if (rd_valid && rd_ready) begin
      n_pop++;
      e = 'x;
      if (exp_q.size() != 0) e = 128'(exp_q.pop_front());
      chk("rd_beat", {rd_data, rd_keep, rd_user, rd_last}, e);
    end
    if (desc_valid && desc_ready) begin
      e = 'x;
      if (desc_q.size() != 0) e = 128'(desc_q.pop_front());
      chk("desc", desc, e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                          input logic [7:0] id, input logic [7:0] ds);
    s_axis.tdata = d;
    s_axis.tkeep = k;
    s_axis.tstrb = 4'($urandom);
    s_axis.tuser = $urandom;
    s_axis.tlast = l;
    s_axis.tid = id;
    s_axis.tdest = ds;
  endtask
  task automatic offer(input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic [7:0] id, input logic [7:0] ds);
    logic a;
    a = 1'b0;
    set_beat(d, k, l, id, ds);
    s_axis.tvalid = 1'b1;
    for (int c = 0; c < 64 && !a; c++) step(a);
    if (!a) chk("accept_timeout", a, 1);
    s_axis.tvalid = 1'b0;
  endtask
  task automatic settle(input int n);
    logic a;
    rd_ready = 1'b1;
    desc_ready = 1'b1;
    repeat (n) step(a);
  endtask
  initial begin
    logic a;
    int n, n0, nb;
    logic [7:0] id, ds;
    rst_n = 1'b0;
    rd_ready = 1'b0;
    desc_ready = 1'b0;
    s_axis.tvalid = 1'b0;
    set_beat('0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis.tready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc", desc, 0);
    rst_n = 1'b1;
    #1;
    chk("tready_before_edge", s_axis.tready, 0);
    @(negedge clk);
    chk("tready_after_edge", s_axis.tready, 1);
    offer(32'hCAFE0123, 4'b0111, 1'b1, 8'd3, 8'd0);
    chk("single_rd_valid", rd_valid, 1);
    chk("single_rd_last", rd_last, 1);
    chk("single_rd_data", rd_data, 32'hCAFE0123);
    chk("single_desc_valid", desc_valid, 1);
    chk("single_bytes", desc.bytes, 3);
    chk("single_tid", desc.tid, 3);
    chk("single_errs", {desc.err_ovf, desc.err_hdr}, 0);
    settle(1);
    chk("single_rd_drained", rd_valid, 0);
    chk("single_desc_taken", desc_valid, 0);
    n0 = n_pop;
    for (int i = 0; i < 4; i++) offer($urandom, 4'hF, 1'b0, 8'd1, 8'd2);
    chk("multi_desc_early", desc_valid, 0);
    offer($urandom, 4'b0001, 1'b1, 8'd1, 8'd2);
    chk("multi_desc_valid", desc_valid, 1);
    chk("multi_bytes", desc.bytes, 17);
    settle(4);
    chk("multi_reads", n_pop - n0, 5);
    rd_ready = 1'b0;
    n = 0;
    set_beat($urandom, 4'($urandom), 1'b0, 8'd7, 8'd9);
    s_axis.tvalid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      step(a);
      if (a) begin
        n++;
        set_beat($urandom, 4'($urandom), n == 19, 8'd7, 8'd9);
      end
    end
    chk("bp_accepts", n, 16);
    chk("bp_tready", s_axis.tready, 0);
    rd_ready = 1'b1;
    step(a);
    chk("bp_full_pop_no_push", a, 0);
    rd_ready = 1'b0;
    n0 = n;
    for (int c = 0; c < 4; c++) begin
      step(a);
      if (a) begin
        n++;
        set_beat($urandom, 4'($urandom), n == 19, 8'd7, 8'd9);
      end
    end
    chk("bp_one_more", n - n0, 1);
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && n < 20; c++) begin
      step(a);
      if (a) begin
        n++;
        set_beat($urandom, 4'($urandom), n == 19, 8'd7, 8'd9);
      end
    end
    chk("bp_total", n, 20);
    s_axis.tvalid = 1'b0;
    settle(20);
    desc_ready = 1'b0;
    offer(32'hA0A0A0A0, 4'hF, 1'b1, 8'd1, 8'd1);
    set_beat(32'hB0B0B0B0, 4'b0011, 1'b1, 8'd2, 8'd2);
    s_axis.tvalid = 1'b1;
    step(a);
    chk("stall_hold1", a, 0);
    step(a);
    chk("stall_hold2", a, 0);
    desc_ready = 1'b1;
    step(a);
    chk("stall_release_accept", a, 1);
    s_axis.tvalid = 1'b0;
    desc_ready = 1'b0;
    chk("stall_desc2_valid", desc_valid, 1);
    chk("stall_desc2_bytes", desc.bytes, 2);
    settle(3);
    desc_ready = 1'b0;
    offer($urandom, 4'hF, 1'b0, 8'd4, 8'd5);
    offer($urandom, 4'hF, 1'b0, 8'd4, 8'd6);
    offer($urandom, 4'hF, 1'b1, 8'd4, 8'd5);
    chk("hdr_err", desc.err_hdr, 1);
    chk("hdr_ovf", desc.err_ovf, 0);
    chk("hdr_bytes", desc.bytes, 12);
    chk("hdr_tdest", desc.tdest, 5);
    settle(3);
    for (int i = 0; i < 1024; i++) offer($urandom, 4'hF, i == 1023, 8'h11, 8'h22);
    chk("exact_max_bytes", desc.bytes, MAXB);
    chk("exact_max_ovf", desc.err_ovf, 0);
    for (int i = 0; i < 1026; i++) offer($urandom, 4'hF, i == 1025, 8'h11, 8'h22);
    chk("ovf_bytes", desc.bytes, MAXB);
    chk("ovf_flag", desc.err_ovf, 1);
    settle(3);
    rand_rdy = 1'b1;
    for (int p = 0; p < 250; p++) begin
      nb = $urandom_range(1, 6);
      id = 8'($urandom);
      ds = 8'($urandom);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) step(a);
        offer($urandom, 4'($urandom), b == nb - 1,
              $urandom_range(0, 9) == 0 ? id + 8'd1 : id, ds);
      end
    end
    rand_rdy = 1'b0;
    settle(40);
    chk("rand_rd_drained", exp_q.size(), 0);
    chk("rand_desc_drained", desc_q.size(), 0);
    rd_ready = 1'b0;
    desc_ready = 1'b0;
    offer(32'h11111111, 4'hF, 1'b0, 8'd8, 8'd8);
    offer(32'h22222222, 4'hF, 1'b0, 8'd8, 8'd8);
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", s_axis.tready, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_desc_valid", desc_valid, 0);
    chk("midrst_desc", desc, 0);
    exp_q.delete();
    desc_q.delete();
    pk_open = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tready_up", s_axis.tready, 1);
    offer(32'h12345678, 4'hF, 1'b1, 8'd5, 8'd5);
    chk("midrst_rd_data", rd_data, 32'h12345678);
    chk("midrst_bytes", desc.bytes, 4);
    chk("midrst_errs", {desc.err_ovf, desc.err_hdr}, 0);
    settle(3);
    chk("final_rd_valid", rd_valid, 0);
    chk("final_queues", exp_q.size() + desc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_stream_pkt_rx.md
# axi4_stream_pkt_rx

Destination-side AXI4-Stream packet receiver. It terminates an `axi4_stream_if` on its `dst` modport and buffers accepted beats in a synchronous FIFO. For every packet it emits one descriptor giving the byte count, the TID/TDEST and any error flags. It sits between any AXI4-Stream source and a core-side consumer that wants framed packets with length known at end of frame.

## Interface
- `tdata_t`, default `logic [31:0]`: stream data type; `NB = $size(tdata_t)/8` byte lanes.
- `tid_t`, default `logic [7:0]`: TID type.
- `tdest_t`, default `logic [7:0]`: TDEST type.
- `tuser_t`, default `logic [31:0]`: TUSER type. Carried into the FIFO with each beat.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2 and ≥2.
- `MAX_PKT_BYTES`, default 4096: byte-count limit. The counter is `$clog2(MAX_PKT_BYTES+1)` bits wide.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. Synchronous deassertion is the integrator's responsibility.
- `s_axis`, `axi4_stream_if.dst`: input stream. This block drives only `tready`.
- `rd_valid`, out, 1: FIFO head valid.
- `rd_ready`, in, 1: consumer accepts the head.
- `rd_data`, out, `tdata_t`: head data.
- `rd_keep`, out, NB: head TKEEP.
- `rd_user`, out, `tuser_t`: head TUSER.
- `rd_last`, out, 1: head is the last beat of its packet.
- `desc_valid`, out, 1: descriptor available.
- `desc_ready`, in, 1: consumer accepts the descriptor.
- `desc`, out, `pkt_rx_desc_t`: fields `bytes`, `tid`, `tdest`, `err_ovf`, `err_hdr`.

## Operation
- A beat is accepted when `tvalid && tready`. TSTRB is ignored; byte count comes from TKEEP only.
- States:
  - IDLE: no packet open.
  - IN_PKT: packet open, `tid`/`tdest` latched.
- IDLE transitions:
  - Accepted beat with `tlast=0`: go to IN_PKT. Latch `tid`/`tdest`, `bytes = popcount(tkeep)`, clear error flags.
  - Accepted beat with `tlast=1`: single-beat packet. Stay in IDLE and load the descriptor.
- IN_PKT handling, per accepted beat:
  - Add `popcount(tkeep)` to `bytes`, saturating at `MAX_PKT_BYTES`.
  - Set sticky `err_ovf` if the unsaturated sum exceeds `MAX_PKT_BYTES`.
  - Set sticky `err_hdr` if the beat's `tid` or `tdest` differs from the latched values.
  - On `tlast`: load the descriptor and return to IDLE.
- Descriptor content on load: `bytes`, `tid` and `tdest` come from the latched values plus the final beat. Error flags include any error raised by the final beat.
- Null beats (`tkeep=0`) are stored and add 0 bytes. They are not an error.
- Backpressure: `tready = !fifo_full && !(desc_valid && !desc_ready)`.
  - This is a conservative stall: any beat is held while a descriptor is pending unaccepted, because `tready` must not depend on `tlast`.
  - It guarantees the descriptor register never overflows.
- The FIFO stores {tdata, tkeep, tuser, tlast} in order. Data and descriptors are independent streams; the consumer may drain them in any order.

## Timing
- Reset values:
  - `tready=0`, `rd_valid=0`, `desc_valid=0`, `desc='0`.
  - FSM in IDLE; FIFO empty.
  - `tready` rises on the first clock edge after `rst_n` deasserts.
- FIFO latency: a beat accepted in cycle N appears on `rd_*` in cycle N+1.
- FIFO is registered, with no fall-through. Push when full is impossible, because `tready` is low.
- Simultaneous push and pop:
  - When full: the pop is allowed, but `tready` was already 0, so no push occurs.
  - When exactly 1 entry: both occur and the count is unchanged.
- Descriptor latency: `tlast` accepted in cycle N gives `desc_valid=1` in cycle N+1. It is held stable until `desc_ready`.
- `desc_valid && desc_ready` in cycle M: `tready` may be 1 in cycle M.
- `rd_*` and `desc` must stay stable while valid and not ready (AXI rule).
- Reset mid-packet discards all FIFO contents, any partial packet and any pending descriptor.

## Structure
- Package `axi4_stream_pkt_rx_pkg` holds:
  - `pkt_rx_desc_t`, parameterised via the byte-count width localparam pattern or a max-width struct.
  - The popcount function.
- Sub-module `axi4_stream_pkt_rx_fifo`: generic registered synchronous FIFO with `DEPTH` entries. Provides push/pop/full/empty and a `$clog2(DEPTH)+1` count.
- Top level holds the FSM, counters, error logic and descriptor register.

## Test plan
- **Single-beat packet:** `tkeep=4'b0111`, `tlast=1`, `tid=3` → `rd_data` valid next cycle with `rd_last=1`; descriptor `bytes=3`, `tid=3`, no errors.
- **Multi-beat packet:** 5 beats, last `tkeep=4'b0001`, `rd_ready=1` → `bytes=17`, 5 FIFO reads in order, `desc_valid` one cycle after the 5th accept.
- **Backpressure:** `rd_ready=0`, `DEPTH=16`, 20 beats offered → exactly 16 accepted and `tready=0`. Releasing `rd_ready` for 1 cycle → one more beat accepted.
- **Descriptor stall:** two back-to-back 1-beat packets, `desc_ready=0` → second beat held with `tready=0`. Assert `desc_ready` → second accepted the same cycle, second descriptor follows.
- **Errors:** `tdest` changes on beat 2 of 3 → `err_hdr=1`. With `MAX_PKT_BYTES=8`, 3 full beats → `bytes=8`, `err_ovf=1`.
- **Reset mid-packet:** assert `rst_n=0` after 2 of 4 beats → all outputs at reset values. After release, a new 1-beat packet gives `bytes=4` with no stale data.
